// File: rtl/clock_pkg.sv
// Shared definitions for the clock timekeeping block: mode encodings,
// field limits (held as BCD literals) and the two-digit BCD type.
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_HOUR = 2'b01;
    localparam logic [1:0] MODE_SET_MIN  = 2'b10;

    // Limits are written directly in BCD so no conversion is ever needed.
    localparam bcd2_t HOUR_MAX = 8'h23;
    localparam bcd2_t MIN_MAX  = 8'h59;
    localparam bcd2_t SEC_MAX  = 8'h59;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after LIMIT. carry is
// combinational so a chain of counters resolves all carries in one cycle.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd2_t LIMIT = 8'h59
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  clr,
    output bcd2_t value,
    output logic  carry
);

    bcd2_t value_q;
    bcd2_t value_inc;

    assign value = value_q;
    assign carry = inc && !clr && (value_q == LIMIT);

    // Next value on an increment: wrap at LIMIT, else units carry into tens at 9.
    always_comb begin
        value_inc = value_q;
        if (value_q == LIMIT) begin
            value_inc = 8'h00;
        end else if (value_q[3:0] == 4'd9) begin
            value_inc = {value_q[7:4] + 4'd1, 4'd0};
        end else begin
            value_inc = {value_q[7:4], value_q[3:0] + 4'd1};
        end
    end

    // Counter register; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 8'h00;
        end else if (clr) begin
            value_q <= 8'h00;
        end else if (inc) begin
            value_q <= value_inc;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller: 1 Hz tick divider, BCD h:m:s chain,
// two-button set-mode FSM and edit-field blink generator.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output bcd2_t      hour_bcd,
    output bcd2_t      min_bcd,
    output bcd2_t      sec_bcd,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [1:0]    mode_q, mode_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          tick_q, tick_d;

    logic in_run, tick_wrap, set_inc;
    logic sec_inc, sec_clr, sec_carry;
    logic min_inc, min_carry;
    logic hour_inc, hour_carry;

    assign in_run    = (mode_q == MODE_RUN);
    assign tick_wrap = in_run && (tick_cnt_q == TICK_LAST);
    // A mode press in the same cycle discards the increment.
    assign set_inc   = btn_inc && !btn_mode;

    // Increment/carry steering; field carries only propagate while running.
    always_comb begin
        sec_inc  = tick_wrap;
        sec_clr  = (mode_q == MODE_SET_MIN) && btn_mode;
        min_inc  = sec_carry || ((mode_q == MODE_SET_MIN) && set_inc);
        hour_inc = (in_run && min_carry) || ((mode_q == MODE_SET_HOUR) && set_inc);
    end

    // Mode FSM: RUN -> SET_HOUR -> SET_MIN -> RUN on each mode press.
    always_comb begin
        mode_d = mode_q;
        if (btn_mode) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_d = MODE_SET_MIN;
                MODE_SET_MIN:  mode_d = MODE_RUN;
                default:       mode_d = MODE_RUN;
            endcase
        end
    end

    // Tick divider: counts only while staying in RUN, restarts on entering RUN.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (mode_d != MODE_RUN || !in_run || tick_wrap) begin
            tick_cnt_d = '0;
        end
        // A tick coinciding with entry to SET_HOUR still advances time but is not flagged.
        tick_d = tick_wrap && !btn_mode;
    end

    // Blink divider: forced on in RUN, restarted dark on entry to either SET mode.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (mode_d == MODE_RUN) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (btn_mode) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = !blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_RUN;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            tick_q      <= tick_d;
        end
    end

    bcd_mod_counter #(
        .LIMIT (SEC_MAX)
    ) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .value (sec_bcd),
        .carry (sec_carry)
    );

    bcd_mod_counter #(
        .LIMIT (MIN_MAX)
    ) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (min_bcd),
        .carry (min_carry)
    );

    bcd_mod_counter #(
        .LIMIT (HOUR_MAX)
    ) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (hour_inc),
        .clr   (1'b0),
        .value (hour_bcd),
        .carry (hour_carry)
    );

    assign mode  = mode_q;
    assign blink = blink_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: directed scenarios plus random
// button traffic, all compared against an integer-arithmetic clock model.
module tb_clock_time_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       blink;
    logic       tick;

    clock_time_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour_bcd (hour_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .mode     (mode),
        .blink    (blink),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int tick_seen = 0;

    // Reference model: plain integers, mode 0 RUN / 1 SET_HOUR / 2 SET_MIN.
    int m_h, m_m, m_s, m_mode, m_div, m_bcnt;
    bit m_blink, m_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
        m_div = 0; m_bcnt = 0; m_blink = 1'b1; m_tick = 1'b0;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        int total;
        m_tick = 1'b0;
        if (m_mode == 0) begin
            m_div++;
            if (m_div == TICK_DIV) begin
                m_div = 0;
                total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = total / 3600;
                m_m = (total / 60) % 60;
                m_s = total % 60;
                m_tick = !bm;
            end
        end
        if (bm) begin
            if (m_mode == 0) begin
                m_mode = 1; m_div = 0; m_bcnt = 0; m_blink = 1'b0;
            end else if (m_mode == 1) begin
                m_mode = 2; m_bcnt = 0; m_blink = 1'b0;
            end else begin
                m_mode = 0; m_s = 0; m_div = 0; m_bcnt = 0; m_blink = 1'b1;
            end
        end else begin
            if (m_mode == 1 && bi) m_h = (m_h + 1) % 24;
            if (m_mode == 2 && bi) m_m = (m_m + 1) % 60;
            if (m_mode != 0) begin
                m_bcnt++;
                if (m_bcnt == BLINK_DIV) begin
                    m_bcnt = 0;
                    m_blink = !m_blink;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_hour"}, 32'(hour_bcd), 32'(to_bcd(m_h)));
        check_eq({tag, "_min"}, 32'(min_bcd), 32'(to_bcd(m_m)));
        check_eq({tag, "_sec"}, 32'(sec_bcd), 32'(to_bcd(m_s)));
        check_eq({tag, "_mode"}, 32'(mode), 32'(m_mode));
        check_eq({tag, "_blink"}, 32'(blink), 32'(m_blink));
        check_eq({tag, "_tick"}, 32'(tick), 32'(m_tick));
    endtask

    // One clock: drive buttons, step model at the edge, compare #1 later.
    task automatic cycle(input bit bm, input bit bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        model_step(bm, bi);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        compare_all("cyc");
        if (tick) tick_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        int first;
        rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 compare_all("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        compare_all("reset_rel");

        // 1. free run for one minute
        tick_seen = 0;
        idle(240);
        check_eq("t1_ticks", tick_seen, 60);
        check_eq("t1_min", 32'(min_bcd), 32'h01);
        check_eq("t1_sec", 32'(sec_bcd), 32'h00);

        // 2. set 23:59:00, run to :58, then two ticks through midnight
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 24 && m_h != 23; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 60 && m_m != 59; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        idle(58 * TICK_DIV);
        check_eq("t2_sec58", 32'(sec_bcd), 32'h58);
        idle(TICK_DIV);
        check_eq("t2_hour_a", 32'(hour_bcd), 32'h23);
        check_eq("t2_min_a", 32'(min_bcd), 32'h59);
        check_eq("t2_sec_a", 32'(sec_bcd), 32'h59);
        idle(TICK_DIV);
        check_eq("t2_hour_b", 32'(hour_bcd), 32'h00);
        check_eq("t2_min_b", 32'(min_bcd), 32'h00);
        check_eq("t2_sec_b", 32'(sec_bcd), 32'h00);
        check_eq("t2_tick", 32'(tick), 32'h1);

        // 3. SET_HOUR: blink phase, increments, full wrap
        cycle(1'b1, 1'b0);
        check_eq("t3_mode", 32'(mode), 32'h1);
        check_eq("t3_blink0", 32'(blink), 32'h0);
        idle(BLINK_DIV);
        check_eq("t3_blink1", 32'(blink), 32'h1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        check_eq("t3_hour5", 32'(hour_bcd), 32'h05);
        for (int i = 0; i < 19; i++) cycle(1'b0, 1'b1);
        check_eq("t3_hour_wrap", 32'(hour_bcd), 32'h00);
        idle(6);

        // 5. mode and inc together in SET_HOUR
        cycle(1'b1, 1'b1);
        check_eq("t5_mode", 32'(mode), 32'h2);
        check_eq("t5_hour", 32'(hour_bcd), 32'h00);

        // 4. SET_MIN wrap without hour carry, back to RUN
        for (int i = 0; i < 60 && m_m != 59; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        check_eq("t4_min", 32'(min_bcd), 32'h00);
        check_eq("t4_hour", 32'(hour_bcd), 32'h00);
        cycle(1'b1, 1'b0);
        check_eq("t4_mode", 32'(mode), 32'h0);
        check_eq("t4_sec", 32'(sec_bcd), 32'h00);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b0);
            if (tick && first == 0) first = i;
            if (first != 0) break;
        end
        check_eq("t4_first_tick", first, TICK_DIV);

        // mode press on a tick cycle: increment lands, then SET_HOUR
        idle(TICK_DIV - 1);
        cycle(1'b1, 1'b0);
        check_eq("tm_sec", 32'(sec_bcd), 32'h02);
        check_eq("tm_mode", 32'(mode), 32'h1);
        check_eq("tm_tick", 32'(tick), 32'h0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        // random button traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
        end

        // 6. asynchronous reset mid-SET_MIN
        for (int i = 0; i < 3 && m_mode != 2; i++) cycle(1'b1, 1'b0);
        idle(1);
        check_eq("t6_premode", 32'(mode), 32'h2);
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all("t6_async");
        @(posedge clk);
        #1 rst = 1'b0;
        compare_all("t6_held");
        idle(2 * TICK_DIV + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping and time-set controller for the digital clock. It divides the system clock into a 1 Hz tick and runs a BCD hours:minutes:seconds counter chain. A two-button mode FSM lets the user set the hour and minute fields. Its BCD fields feed the display path's digit converters and seven-segment drivers.

## Interface

Parameters:
- `TICK_DIV`, default 50_000_000: `clk` cycles per one-second tick (minimum 2).
- `BLINK_DIV`, default 25_000_000: `clk` cycles per blink half-period (minimum 1).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_mode`  in  1  single-cycle pulse, already debounced; advances the mode.
- `btn_inc`  in  1  single-cycle pulse, already debounced; increments the field being edited.
- `hour_bcd`  out  8  [7:4] tens 0–2, [3:0] units 0–9; value 00–23.
- `min_bcd`  out  8  BCD minutes, 00–59.
- `sec_bcd`  out  8  BCD seconds, 00–59.
- `mode`  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 is never driven.
- `blink`  out  1  1 = show the field being edited; always 1 in RUN.
- `tick`  out  1  one-cycle pulse on each one-second tick; RUN only.

## Operation

**Reset** (asynchronous, takes effect immediately):
- Time = 00:00:00, `mode` = RUN, `blink` = 1, `tick` = 0.
- Tick divider = 0, blink divider = 0.

**Tick divider:**
- Counts 0..TICK_DIV-1 in RUN only.
- `tick` = 1 for the cycle in which the count wraps from TICK_DIV-1 to 0.
- In SET modes the divider is held at 0 and `tick` = 0.

**RUN:**
- Each tick increments `sec_bcd`.
- 59→00 on seconds carries into minutes; 59→00 on minutes carries into hours; 23→00 on hours wraps to midnight.
- All carries resolve in the same cycle: 23:59:59 → 00:00:00 in one update.
- `btn_inc` is ignored.

**Mode FSM** (`btn_mode` advances it):
- RUN → SET_HOUR: seconds freeze; blink divider cleared; `blink` set to 0.
- SET_HOUR → SET_MIN: blink divider cleared; `blink` set to 0.
- SET_MIN → RUN: `sec_bcd` cleared to 00; tick divider restarts from 0; `blink` = 1.

**SET_HOUR:**
- `btn_inc` increments hours mod 24 (23→00).
- Minutes and seconds are unchanged.

**SET_MIN:**
- `btn_inc` increments minutes mod 60 (59→00).
- No carry into hours.

**Blink:**
- In SET modes, `blink` toggles every BLINK_DIV cycles.

**Simultaneous events:**
- `btn_mode` and `btn_inc` in the same cycle: the mode change wins and the increment is discarded.
- `btn_mode` in a RUN cycle that also ticks: the tick's increment is applied, then the mode enters SET_HOUR.

**Arithmetic:**
- Each BCD digit stays within its legal range at all times.
- Units carry into tens at 9→0.
- No binary-to-BCD conversion anywhere in the block.

## Timing

- All outputs are registered.
- Latency from a button pulse (sampled at edge N) to the updated outputs: visible after edge N.
- A tick in the cycle ending at edge N increments the time at edge N, coincident with `tick` going high.
- Seconds period in RUN: exactly TICK_DIV cycles.
- First tick after reset or after SET_MIN → RUN: TICK_DIV cycles later.
- Blink period: 2×BLINK_DIV cycles. First toggle occurs BLINK_DIV cycles after entering a SET mode.
- Reset during a SET mode returns to RUN, 00:00:00, with no residual state.
- Back-to-back `btn_inc` pulses on consecutive cycles each increment once.

## Structure

Shared package `clock_pkg`:
- Mode encodings: RUN, SET_HOUR, SET_MIN.
- Constants: HOUR_MAX = 23, MIN_MAX = 59, SEC_MAX = 59.
- Typedef for an 8-bit two-digit BCD value.

Sub-module `bcd_mod_counter`:
- Parameter: modulus limit.
- Inputs: `inc`, `clr`. Outputs: 8-bit BCD value, `carry` (asserted when wrapping to 00 on `inc`).
- Instantiated three times (hours, minutes, seconds).

The top level contains the mode FSM, the tick and blink dividers, and the increment/carry steering.

## Test plan

Run with TICK_DIV = 4, BLINK_DIV = 2.

1. Reset, run 240 cycles → `sec_bcd` = 8'h00 after wrapping, `min_bcd` = 8'h01, exactly 60 `tick` pulses.
2. Set time to 23:59:58, allow 2 ticks → 23:59:59, then 00:00:00 at the second tick edge.
3. `btn_mode`, then 5× `btn_inc` → `mode` = 01, `hour_bcd` increments once per pulse; 24 pulses in total return to the start value; `tick` stays 0; `blink` toggles every 2 cycles.
4. In SET_MIN at 59, `btn_inc` → `min_bcd` = 8'h00, `hour_bcd` unchanged. `btn_mode` → RUN, `sec_bcd` = 8'h00, first tick 4 cycles later.
5. `btn_mode` and `btn_inc` in the same cycle in SET_HOUR → `mode` = 10, hours unchanged.
6. Assert `rst` mid-SET_MIN between clock edges → outputs reach 00:00:00, `mode` = 00, `blink` = 1 before the next edge.
